// File: rtl/speech_endpoint_detector.sv
// speech_endpoint_detector
//   Turns a stream of 8-bit offset-binary audio samples into per-frame energy
//   and decides where a spoken word starts and ends using an onset/hangover
//   state machine. Word boundaries and word length feed the template-compare
//   logic; frame energy is also exposed for an LED-bar debug display.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   enable        detector run enable; low clears the frame and the FSM
//   sample_valid  one-cycle strobe per new sample (back-to-back allowed)
//   sample        unsigned offset-binary sample, 0x80 = silence
//   threshold     loudness threshold; a frame is loud if energy > threshold
//   frame_valid   one-cycle strobe: frame_energy has just been updated
//   frame_energy  sum of sample magnitudes over the last frame
//   speech_active high while in SPEECH or HANGOVER
//   speech_start  one-cycle pulse at declared word start
//   speech_end    one-cycle pulse at declared word end
//   word_frames   word length in frames, latched at speech_end
//   forced_end    latched with word_frames: 1 if the word hit MAX_FRAMES
//   state_dbg     current FSM state encoding
module speech_endpoint_detector #(
  parameter  int FRAME_LEN    = 64,
  parameter  int ONSET_FRAMES = 3,
  parameter  int HANG_FRAMES  = 8,
  parameter  int MAX_FRAMES   = 255,
  localparam int ENERGY_W     = 8 + $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [7:0]          sample,
  input  logic [ENERGY_W-1:0] threshold,
  output logic                frame_valid,
  output logic [ENERGY_W-1:0] frame_energy,
  output logic                speech_active,
  output logic                speech_start,
  output logic                speech_end,
  output logic [7:0]          word_frames,
  output logic                forced_end,
  output logic [2:0]          state_dbg
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  localparam logic [2:0] SILENCE  = 3'd0;
  localparam logic [2:0] ONSET    = 3'd1;
  localparam logic [2:0] SPEECH   = 3'd2;
  localparam logic [2:0] HANGOVER = 3'd3;

  localparam logic [3:0] ONSET_N = 4'(ONSET_FRAMES);
  localparam logic [3:0] HANG_N  = 4'(HANG_FRAMES);
  localparam logic [7:0] MAX_N   = 8'(MAX_FRAMES);

  logic [ENERGY_W-1:0] acc;
  logic [CNT_W-1:0]    count;
  logic [7:0]          mag;

  logic [2:0] state;
  logic [3:0] cnt;        // onset / hangover run length
  logic [7:0] wcnt;       // frames in the current word candidate
  logic [7:0] wcnt_inc;   // wcnt + 1, saturated at MAX_FRAMES
  logic       loud;
  logic       at_cap;

  // Distance from the 0x80 midpoint; 0x00 maps to 128, 0xFF to 127.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    mag = sample[7] ? {1'b0, sample[6:0]} : 8'd128 - sample;
  end

  // ---------------------------------------------------------------------------
  // Frame accumulator. The last sample of a frame is folded in directly so
  // acc/count can clear on the same edge and the next frame starts cleanly
  // even with back-to-back strobes.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      count        <= '0;
      frame_energy <= '0;
      frame_valid  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (!enable) begin
        acc   <= '0;
        count <= '0;
      end else if (sample_valid) begin
        if (count == CNT_W'(FRAME_LEN - 1)) begin
          frame_energy <= acc + ENERGY_W'(mag);
          acc          <= '0;
          count        <= '0;
          frame_valid  <= 1'b1;
        end else begin
          acc   <= acc + ENERGY_W'(mag);
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    loud     = frame_energy > threshold;
    wcnt_inc = (wcnt >= MAX_N) ? MAX_N : wcnt + 8'd1;
    at_cap   = (wcnt_inc == MAX_N);
  end

  // ---------------------------------------------------------------------------
  // Onset / hangover FSM, stepped once per completed frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SILENCE;
      cnt          <= '0;
      wcnt         <= '0;
      speech_start <= 1'b0;
      speech_end   <= 1'b0;
      word_frames  <= '0;
      forced_end   <= 1'b0;
    end else begin
      speech_start <= 1'b0;
      speech_end   <= 1'b0;
      if (!enable) begin
        // Abandon any word silently; the last reported length stays visible.
        state <= SILENCE;
        cnt   <= '0;
        wcnt  <= '0;
      end else if (frame_valid) begin
        case (state)
          SILENCE: begin
            if (loud) begin
              wcnt <= 8'd1;
              cnt  <= 4'd1;
              if (ONSET_N == 4'd1) begin
                state        <= SPEECH;
                speech_start <= 1'b1;
              end else begin
                state <= ONSET;
              end
            end
          end
          ONSET: begin
            if (loud) begin
              wcnt <= wcnt_inc;
              cnt  <= cnt + 4'd1;
              if (cnt + 4'd1 == ONSET_N) begin
                state        <= SPEECH;
                speech_start <= 1'b1;
              end
            end else begin
              state <= SILENCE;
              cnt   <= '0;
              wcnt  <= '0;
            end
          end
          SPEECH, HANGOVER: begin
            // The length cap wins over every other outcome of this frame.
            if (at_cap) begin
              speech_end  <= 1'b1;
              word_frames <= wcnt_inc;
              forced_end  <= 1'b1;
              state       <= SILENCE;
              cnt         <= '0;
              wcnt        <= '0;
            end else if (loud) begin
              wcnt  <= wcnt_inc;
              state <= SPEECH;
            end else if ((state == SPEECH ? 4'd1 : cnt + 4'd1) == HANG_N) begin
              speech_end  <= 1'b1;
              word_frames <= wcnt_inc;
              forced_end  <= 1'b0;
              state       <= SILENCE;
              cnt         <= '0;
              wcnt        <= '0;
            end else begin
              wcnt  <= wcnt_inc;
              cnt   <= (state == SPEECH) ? 4'd1 : cnt + 4'd1;
              state <= HANGOVER;
            end
          end
          default: begin
            state <= SILENCE;
            cnt   <= '0;
            wcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign speech_active = (state == SPEECH) || (state == HANGOVER);
  assign state_dbg     = state;

endmodule

// File: tb/tb_speech_endpoint_detector.sv
// Directed bench for speech_endpoint_detector with FRAME_LEN=4, ONSET=2,
// HANG=2, MAX=10 and threshold=100. A table of frames with hand-computed
// energies and post-frame FSM outputs drives the main sequence; reset,
// enable and mid-word corner cases are written out by hand.
module tb_speech_endpoint_detector;

  localparam int EW = 10;

  localparam logic [2:0] S_SIL = 3'd0;
  localparam logic [2:0] S_ONS = 3'd1;
  localparam logic [2:0] S_SPE = 3'd2;
  localparam logic [2:0] S_HAN = 3'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sample_valid;
  logic [7:0]    sample;
  logic [EW-1:0] threshold;
  logic          frame_valid;
  logic [EW-1:0] frame_energy;
  logic          speech_active;
  logic          speech_start;
  logic          speech_end;
  logic [7:0]    word_frames;
  logic          forced_end;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  speech_endpoint_detector #(
    .FRAME_LEN   (4),
    .ONSET_FRAMES(2),
    .HANG_FRAMES (2),
    .MAX_FRAMES  (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample       (sample),
    .threshold    (threshold),
    .frame_valid  (frame_valid),
    .frame_energy (frame_energy),
    .speech_active(speech_active),
    .speech_start (speech_start),
    .speech_end   (speech_end),
    .word_frames  (word_frames),
    .forced_end   (forced_end),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   smp;     // four samples, first in the top byte
    logic [EW-1:0] energy;
    logic          start;
    logic          stop;
    logic          active;
    logic [2:0]    state;
    logic [7:0]    word;
    logic          forced;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] s);
    sample       = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Sends one frame, checks the energy strobe, then steps the FSM once and
  // checks the pulses and state that follow.
  task automatic run_frame(input vec_t v, input int gap, input int idx);
    logic [31:0] s;
    s = v.smp;
    for (int i = 0; i < 4; i++) begin
      strobe(s[31-8*i -: 8]);
      if (i == 2) check($sformatf("fv_early[%0d]", idx), 32'(frame_valid), 32'd0);
      if (i < 3) repeat (gap) tick();
    end
    check($sformatf("fv[%0d]", idx), 32'(frame_valid), 32'd1);
    check($sformatf("energy[%0d]", idx), 32'(frame_energy), 32'(v.energy));
    tick();
    check($sformatf("fv_drop[%0d]", idx), 32'(frame_valid), 32'd0);
    check($sformatf("start[%0d]", idx), 32'(speech_start), 32'(v.start));
    check($sformatf("end[%0d]", idx), 32'(speech_end), 32'(v.stop));
    check($sformatf("active[%0d]", idx), 32'(speech_active), 32'(v.active));
    check($sformatf("state[%0d]", idx), 32'(state_dbg), 32'(v.state));
    check($sformatf("word[%0d]", idx), 32'(word_frames), 32'(v.word));
    check($sformatf("forced[%0d]", idx), 32'(forced_end), 32'(v.forced));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fv"},     32'(frame_valid),   32'd0);
    check({tag, "_energy"}, 32'(frame_energy),  32'd0);
    check({tag, "_active"}, 32'(speech_active), 32'd0);
    check({tag, "_start"},  32'(speech_start),  32'd0);
    check({tag, "_end"},    32'(speech_end),    32'd0);
    check({tag, "_word"},   32'(word_frames),   32'd0);
    check({tag, "_forced"}, 32'(forced_end),    32'd0);
    check({tag, "_state"},  32'(state_dbg),     32'(S_SIL));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           samples        energy start end act state  word  forced
    vecs[0]  = '{32'h80FF0090, 10'd271, 1'b0, 1'b0, 1'b0, S_ONS, 8'd0,  1'b0};
    vecs[1]  = '{32'h99999999, 10'd100, 1'b0, 1'b0, 1'b0, S_SIL, 8'd0,  1'b0};
    vecs[2]  = '{32'hB2B2B2B2, 10'd200, 1'b0, 1'b0, 1'b0, S_ONS, 8'd0,  1'b0};
    vecs[3]  = '{32'h80808080, 10'd0,   1'b0, 1'b0, 1'b0, S_SIL, 8'd0,  1'b0};
    vecs[4]  = '{32'hB2B2B2B2, 10'd200, 1'b0, 1'b0, 1'b0, S_ONS, 8'd0,  1'b0};
    vecs[5]  = '{32'hB2B2B2B2, 10'd200, 1'b1, 1'b0, 1'b1, S_SPE, 8'd0,  1'b0};
    vecs[6]  = '{32'h80808080, 10'd0,   1'b0, 1'b0, 1'b1, S_HAN, 8'd0,  1'b0};
    vecs[7]  = '{32'hB2B2B2B2, 10'd200, 1'b0, 1'b0, 1'b1, S_SPE, 8'd0,  1'b0};
    vecs[8]  = '{32'h80808080, 10'd0,   1'b0, 1'b0, 1'b1, S_HAN, 8'd0,  1'b0};
    vecs[9]  = '{32'h80808080, 10'd0,   1'b0, 1'b1, 1'b0, S_SIL, 8'd6,  1'b0};
    vecs[10] = '{32'h9999999A, 10'd101, 1'b0, 1'b0, 1'b0, S_ONS, 8'd6,  1'b0};
    vecs[11] = '{32'hB2B2B2B2, 10'd200, 1'b1, 1'b0, 1'b1, S_SPE, 8'd6,  1'b0};
    vecs[12] = '{32'hC83080FF, 10'd279, 1'b0, 1'b0, 1'b1, S_SPE, 8'd6,  1'b0};
    vecs[13] = '{32'h00000000, 10'd512, 1'b0, 1'b0, 1'b1, S_SPE, 8'd6,  1'b0};
    vecs[14] = '{32'hE61AB24E, 10'd304, 1'b0, 1'b0, 1'b1, S_SPE, 8'd6,  1'b0};
    vecs[15] = '{32'hB2B2B2B2, 10'd200, 1'b0, 1'b0, 1'b1, S_SPE, 8'd6,  1'b0};
    vecs[16] = '{32'hB2B2B2B2, 10'd200, 1'b0, 1'b0, 1'b1, S_SPE, 8'd6,  1'b0};
    vecs[17] = '{32'hB2B2B2B2, 10'd200, 1'b0, 1'b0, 1'b1, S_SPE, 8'd6,  1'b0};
    vecs[18] = '{32'hB2B2B2B2, 10'd200, 1'b0, 1'b0, 1'b1, S_SPE, 8'd6,  1'b0};
    vecs[19] = '{32'hB2B2B2B2, 10'd200, 1'b0, 1'b1, 1'b0, S_SIL, 8'd10, 1'b1};
    vecs[20] = '{32'hB2B2B2B2, 10'd200, 1'b0, 1'b0, 1'b0, S_ONS, 8'd10, 1'b1};
    vecs[21] = '{32'hB2B2B2B2, 10'd200, 1'b1, 1'b0, 1'b1, S_SPE, 8'd10, 1'b1};

    reset        = 1'b1;
    enable       = 1'b1;
    sample_valid = 1'b0;
    sample       = 8'h80;
    threshold    = 10'd100;

    // Reset state after a 3-cycle reset.
    repeat (3) tick();
    reset = 1'b0;
    check_idle_outputs("reset");

    // Reset in the middle of a frame drops the two loud samples already taken.
    strobe(8'h00);
    tick();
    strobe(8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    strobe(8'h81);
    tick();
    strobe(8'h81);
    check("midframe_no_fv", 32'(frame_valid), 32'd0);
    tick();
    strobe(8'h81);
    tick();
    strobe(8'h81);
    check("midframe_fv", 32'(frame_valid), 32'd1);
    check("midframe_energy", 32'(frame_energy), 32'd4);
    tick();
    check("midframe_state", 32'(state_dbg), 32'(S_SIL));

    // Main table: energy, onset, hangover, natural end, length cap, restart.
    for (int i = 0; i < 22; i++) run_frame(vecs[i], i % 2, i);

    // Enable drop in SPEECH: silent abandon, word length held, strobes ignored.
    enable = 1'b0;
    tick();
    check("dis_active", 32'(speech_active), 32'd0);
    check("dis_end", 32'(speech_end), 32'd0);
    check("dis_state", 32'(state_dbg), 32'(S_SIL));
    check("dis_word", 32'(word_frames), 32'd10);
    check("dis_forced", 32'(forced_end), 32'd1);
    for (int i = 0; i < 5; i++) begin
      strobe(8'h00);
      check($sformatf("dis_fv[%0d]", i), 32'(frame_valid), 32'd0);
      tick();
      check($sformatf("dis_fv_gap[%0d]", i), 32'(frame_valid), 32'd0);
    end
    enable = 1'b1;
    tick();
    run_frame('{32'h80808080, 10'd0, 1'b0, 1'b0, 1'b0, S_SIL, 8'd10, 1'b1}, 1, 100);

    // Reset mid-word: no end pulse, everything back to zero.
    run_frame('{32'hB2B2B2B2, 10'd200, 1'b0, 1'b0, 1'b0, S_ONS, 8'd10, 1'b1}, 1, 101);
    run_frame('{32'hB2B2B2B2, 10'd200, 1'b1, 1'b0, 1'b1, S_SPE, 8'd10, 1'b1}, 0, 102);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("midword_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
